// File: rtl/slow_clk_monitor.sv
// rtl/slow_clk_monitor.sv - measures slow_clk half periods against EXPECTED_HALF and tracks lock/fault
// Optional stall detection: define SLOW_CLK_MONITOR_TIMEOUT_EN.
module slow_clk_monitor #(
  parameter int unsigned EXPECTED_HALF = 100_000_001,
  parameter int unsigned TOLERANCE     = 16,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        clear_fault,
  output logic        tick,
  output logic [26:0] half_period,
  output logic        locked,
  output logic        fault,
  output logic        timeout
);

  localparam logic [27:0] EXP_W    = 28'(EXPECTED_HALF);
  localparam logic [27:0] TOL_W    = 28'(TOLERANCE);
  localparam logic [27:0] HI_LIMIT = EXP_W + TOL_W;
  localparam logic [7:0]  LOCK_W   = 8'(LOCK_COUNT);
  localparam logic [26:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  good_cnt;
  logic [7:0]  good_next;
  logic [26:0] cnt;
  logic        sync_a;
  logic        sync_b;
  logic        sync_prev;
  logic        edge_any;
  logic        edge_rise;
  logic [27:0] meas_w;
  logic [27:0] diff;
  logic        in_range;
  logic        stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_a    <= slow_clk;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
    end
  end

  assign edge_any  = sync_b ^ sync_prev;
  assign edge_rise = sync_b & ~sync_prev;

  // Counter value at an edge is the exact distance from the previous edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (edge_any) begin
      cnt <= 27'd1;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 27'd1;
    end
  end

  // 28-bit ordered difference so no wrap-around can fake an in-range result.
  assign meas_w   = {1'b0, cnt};
  assign diff     = (meas_w >= EXP_W) ? (meas_w - EXP_W) : (EXP_W - meas_w);
  assign in_range = (diff <= TOL_W);

`ifdef SLOW_CLK_MONITOR_TIMEOUT_EN
  assign stall = !edge_any && (state == MEASURE || state == LOCKED) && (meas_w > HI_LIMIT);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    if (state == FAULT && clear_fault) begin
      state_next = IDLE;
      good_next  = 8'd0;
    end else if (edge_any) begin
      case (state)
        IDLE: begin
          state_next = MEASURE;
          good_next  = 8'd0;
        end
        MEASURE: begin
          if (in_range) begin
            good_next = good_cnt + 8'd1;
            if (good_next >= LOCK_W) begin
              state_next = LOCKED;
            end
          end else begin
            good_next = 8'd0;
          end
        end
        LOCKED: begin
          if (!in_range) begin
            state_next = FAULT;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end else if (stall) begin
      state_next = FAULT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      good_cnt    <= 8'd0;
      tick        <= 1'b0;
      half_period <= '0;
      locked      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      tick     <= edge_rise;
      if (edge_any && state != IDLE) begin
        half_period <= cnt;
      end
      locked <= (state_next == LOCKED);
      fault  <= (state_next == FAULT);
    end
  end

`ifdef SLOW_CLK_MONITOR_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (state == FAULT && clear_fault) begin
      timeout <= 1'b0;
    end else if (stall) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/slow_clk_monitor.md
SLOW_CLK_MONITOR -- requirements
Module: slow_clk_monitor

Interface
REQ-001 The block SHALL have parameter EXPECTED_HALF, default 100_000_001, giving the nominal clk cycles between consecutive slow_clk transitions.
REQ-002 The block SHALL have parameter TOLERANCE, default 16, giving the allowed +/- deviation in clk cycles.
REQ-003 The block SHALL have parameter LOCK_COUNT, default 4, giving the consecutive in-range measurements needed to lock; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit, the single fast system clock.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port slow_clk, input, 1 bit, the divided clock, asynchronous to clk's sampling point.
REQ-007 The block SHALL have port clear_fault, input, 1 bit, a synchronous one-cycle request to leave FAULT.
REQ-008 The block SHALL have port tick, output, 1 bit, a one-cycle pulse per detected slow_clk rising edge.
REQ-009 The block SHALL have port half_period, output, 27 bits, the last measured interval in clk cycles.
REQ-010 The block SHALL have ports locked, fault and timeout, outputs, 1 bit each, the status flags.

Function
REQ-011 slow_clk SHALL pass a 2-flop synchronizer, and a third flop SHALL hold the previous synchronized value; an edge is detected when the last two flops differ.
REQ-012 All effects of an edge (tick, half_period, state update) SHALL be registered on the 3rd rising clk edge after the edge that first samples the new slow_clk level.
REQ-013 tick SHALL be high for exactly one cycle on rising edges only; both rising and falling edges SHALL be measured.
REQ-014 A 27-bit interval counter SHALL increment every cycle, saturate at 2^27-1, and be loaded with 1 on each detected edge.
REQ-015 On each detected edge outside IDLE, half_period SHALL load the counter value, i.e. the exact clk-cycle distance between the two detected edges.
REQ-016 A measurement SHALL be in range when |half_period - EXPECTED_HALF| <= TOLERANCE, and the comparison SHALL be performed without wrap-around (28-bit or ordered compare).
REQ-017 The FSM SHALL have four states: IDLE, MEASURE, LOCKED and FAULT.
REQ-018 In IDLE, the first detected edge SHALL move the FSM to MEASURE; that edge starts the counter but SHALL NOT update half_period.
REQ-019 In MEASURE, an in-range edge SHALL increment an 8-bit good-count, and an out-of-range edge SHALL clear it; when the good-count reaches LOCK_COUNT, the FSM SHALL move to LOCKED on that same edge.
REQ-020 In LOCKED, an out-of-range measurement SHALL move the FSM to FAULT.
REQ-021 FAULT SHALL be sticky: edges still update tick and half_period but SHALL NOT change state.
REQ-022 clear_fault SHALL move the FSM from FAULT to IDLE and clear the good-count and timeout; it has no effect in other states.
REQ-023 If clear_fault and an edge occur in the same cycle, clear_fault SHALL win and the edge SHALL be discarded for FSM purposes.
REQ-024 locked SHALL equal (state==LOCKED), and fault SHALL equal (state==FAULT), both registered.

Reset
REQ-025 Reset SHALL clear all synchronizer flops, the counter, the good-count, half_period, tick, locked, fault and timeout to 0, and set the state to IDLE.
REQ-026 Reset asserted mid-measurement SHALL abort the measurement immediately, and the first edge after release SHALL be treated as an IDLE first edge.

Configuration
REQ-027 With SLOW_CLK_MONITOR_TIMEOUT_EN defined, in MEASURE or LOCKED, the counter exceeding EXPECTED_HALF+TOLERANCE with no edge SHALL force FAULT and set timeout=1 in that cycle.
REQ-028 Without SLOW_CLK_MONITOR_TIMEOUT_EN, timeout SHALL be tied to 0 and a stalled slow_clk SHALL only saturate the counter.

Verification (EXPECTED_HALF=10, TOLERANCE=1, LOCK_COUNT=3)
REQ-029 Assert reset, then toggle slow_clk -> all outputs are 0 during reset and no tick occurs while reset is held.
REQ-030 slow_clk toggles every 10 clk cycles -> tick occurs every 20 cycles, half_period=10 after the 2nd edge, and locked=1 in the same cycle as the 4th detected edge.
REQ-031 While LOCKED, one interval of 13 cycles -> fault=1 and locked=0 with that edge, and half_period=13.
REQ-032 In FAULT, pulse clear_fault in the same cycle as a detected edge -> state becomes IDLE, fault=0, and the next edge causes no half_period update.
REQ-033 With the macro defined, stop slow_clk while LOCKED -> timeout=1 and fault=1 when the counter reaches 12; without the macro, timeout stays 0 and locked stays 1.
REQ-034 Assert reset 5 cycles into a MEASURE interval -> all outputs return to 0 immediately, and a relock requires 1 + 3 good edges.
